// File: rtl/fifo_rd_unpacker_if.sv
// Read-side bundle of the 16-to-32 asymmetric FIFO plus the 16-bit beat stream toward display.
// master: the unpacker (issues reads, drives the stream); slave: the FIFO/display environment.
interface fifo_rd_unpacker_if;
    logic        fifo_rst_busy_i;
    logic        fifo_empty_i;
    logic        fifo_prog_full_i;
    logic        fifo_rd_valid_i;
    logic [31:0] fifo_rdata_i;
    logic        fifo_rd_en_o;
    logic [15:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        seq_error_o;
    logic        underrun_o;
    logic [15:0] underrun_cnt_o;

    modport master (
        input  fifo_rst_busy_i, fifo_empty_i, fifo_prog_full_i,
        input  fifo_rd_valid_i, fifo_rdata_i, m_ready_i,
        output fifo_rd_en_o, m_data_o, m_valid_o,
        output seq_error_o, underrun_o, underrun_cnt_o
    );

    modport slave (
        output fifo_rst_busy_i, fifo_empty_i, fifo_prog_full_i,
        output fifo_rd_valid_i, fifo_rdata_i, m_ready_i,
        input  fifo_rd_en_o, m_data_o, m_valid_o,
        input  seq_error_o, underrun_o, underrun_cnt_o
    );
endinterface

// File: rtl/fifo_rd_unpacker.sv
// Pulls 32-bit words from the FIFO with credit-limited reads, splits them into two 16-bit beats
// (older half first), checks the incrementing test pattern and counts underrun cycles.
module fifo_rd_unpacker #(
    parameter int unsigned RD_LATENCY         = 1,
    parameter int unsigned BUF_WORDS          = RD_LATENCY + 1,
    parameter bit          START_ON_PROG_FULL = 1'b1,
    parameter bit          CHECK_SEQ          = 1'b1
) (
    input  logic               rd_clk_i,
    input  logic               sys_rst_n,
    fifo_rd_unpacker_if.master bus
);

    localparam int unsigned PTR_W     = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
    localparam int unsigned MEM_DEPTH = 1 << PTR_W;
    localparam int unsigned CNT_W     = $clog2(BUF_WORDS + 1);
    localparam int unsigned SUM_W     = CNT_W + 1;

    typedef enum logic [1:0] {
        WAIT_RST = 2'd0,
        PRIME    = 2'd1,
        STREAM   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      mem_q [MEM_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] occ_q, inflight_q;
    logic             lower_q;
    logic [15:0]      seq_ref_q;
    logic             seq_armed_q, seq_error_q;
    logic             underrun_q;
    logic [15:0]      underrun_cnt_q;

    logic             flush, start_ok, rd_issue, rd_accept, xfer, pop, starved;
    logic [31:0]      head;
    logic [15:0]      beat;

    assign flush     = bus.fifo_rst_busy_i;
    assign start_ok  = bus.fifo_prog_full_i || (!START_ON_PROG_FULL && !bus.fifo_empty_i);
    // Credits: buffered words plus reads still in the FIFO pipeline never exceed the buffer.
    assign rd_issue  = (state_q == STREAM) && !flush && !bus.fifo_empty_i &&
                       ((SUM_W'(occ_q) + SUM_W'(inflight_q)) < SUM_W'(BUF_WORDS));
    assign rd_accept = bus.fifo_rd_valid_i && (inflight_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign beat      = lower_q ? head[15:0] : head[31:16];
    assign xfer      = (occ_q != '0) && bus.m_ready_i;
    assign pop       = xfer && lower_q;
    assign starved   = (state_q == STREAM) && bus.m_ready_i && (occ_q == '0) && (inflight_q == '0);

    assign bus.fifo_rd_en_o   = rd_issue;
    assign bus.m_valid_o      = (occ_q != '0);
    assign bus.m_data_o       = beat;
    assign bus.seq_error_o    = CHECK_SEQ ? seq_error_q : 1'b0;
    assign bus.underrun_o     = underrun_q;
    assign bus.underrun_cnt_o = underrun_cnt_q;

    always_ff @(posedge rd_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= WAIT_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = WAIT_RST;
        end else begin
            case (state_q)
                WAIT_RST: state_d = PRIME;
                PRIME:    if (start_ok) state_d = STREAM;
                STREAM:   state_d = STREAM;
                default:  state_d = WAIT_RST;
            endcase
        end
    end

    // Word buffer, credit counter and half-select; a flush drops buffered and in-flight words.
    always_ff @(posedge rd_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= '0;
            lower_q    <= 1'b0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= '0;
            lower_q    <= 1'b0;
        end else begin
            if (rd_accept) begin
                mem_q[wr_ptr_q] <= bus.fifo_rdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (xfer) begin
                lower_q <= !lower_q;
            end
            occ_q      <= occ_q + CNT_W'(rd_accept) - CNT_W'(pop);
            inflight_q <= inflight_q + CNT_W'(rd_issue) - CNT_W'(rd_accept);
        end
    end

    // Underrun flags survive flushes; only reset clears them.
    always_ff @(posedge rd_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else if (starved) begin
            underrun_q <= 1'b1;
            if (underrun_cnt_q != 16'hFFFF) begin
                underrun_cnt_q <= underrun_cnt_q + 16'd1;
            end
        end
    end

    // Reference follows the received beat so a single glitch is flagged only once.
    always_ff @(posedge rd_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seq_ref_q   <= '0;
            seq_armed_q <= 1'b0;
            seq_error_q <= 1'b0;
        end else if (flush) begin
            seq_armed_q <= 1'b0;
        end else if (xfer) begin
            seq_ref_q   <= beat;
            seq_armed_q <= 1'b1;
            if (CHECK_SEQ && seq_armed_q && (beat != 16'(seq_ref_q + 16'd1))) begin
                seq_error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Scoreboard bench: a queue-based FIFO model feeds the unpacker; expected beats are queued at write time.
module tb_fifo_rd_unpacker;

    localparam int RD_LAT   = 2;
    localparam int BUF      = RD_LAT + 1;
    localparam int PF_LEVEL = 128;
    localparam int FIFO_CAP = 256;

    typedef struct {
        int          due;
        logic [31:0] d;
    } pend_t;

    logic rd_clk_i  = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 rd_clk_i = ~rd_clk_i;

    fifo_rd_unpacker_if bus ();

    fifo_rd_unpacker #(
        .RD_LATENCY        (RD_LAT),
        .BUF_WORDS         (BUF),
        .START_ON_PROG_FULL(1'b1),
        .CHECK_SEQ         (1'b1)
    ) dut (
        .rd_clk_i (rd_clk_i),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] fifo_q[$];
    logic [15:0] exp_q[$];
    pend_t       pend_q[$];

    // Reference model of the unpacker in terms of words held, reads outstanding and stream phase
    bit          m_prime, m_stream, lower_m, armed, exp_seq, exp_und;
    int          held, inflight, exp_cnt;
    logic [15:0] ref_m;

    logic [15:0] gen_b      = 16'h0000;
    int          gen_idx    = 0;
    bit          corrupt_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input int info);
        n_checks++;
        $display("FAIL %s: info %0d (cycle %0d)", name, info, cyc);
    endtask

    task automatic step(input bit wr, input bit rdy, input bit busy);
        logic [31:0] w;
        @(posedge rd_clk_i);
        #1;
        cyc++;
        if (wr && sys_rst_n && fifo_q.size() < FIFO_CAP) begin
            if (corrupt_en && gen_idx == 2) gen_b = gen_b + 16'd12;
            w = {gen_b, 16'(gen_b + 16'd1)};
            gen_b = gen_b + 16'd2;
            gen_idx++;
            fifo_q.push_back(w);
            exp_q.push_back(w[31:16]);
            exp_q.push_back(w[15:0]);
        end
        bus.fifo_rst_busy_i  = busy;
        bus.m_ready_i        = rdy;
        bus.fifo_empty_i     = (fifo_q.size() == 0);
        bus.fifo_prog_full_i = (fifo_q.size() >= PF_LEVEL);
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            bus.fifo_rd_valid_i = 1'b1;
            bus.fifo_rdata_i    = pend_q[0].d;
        end else begin
            bus.fifo_rd_valid_i = 1'b0;
            bus.fifo_rdata_i    = $urandom;
        end
    endtask

    task automatic fill_to_stream(input string tag, input int wr_every);
        int n = 0;
        while (!m_stream && n < 3000) begin
            step((n % wr_every) == 0, 1'b1, 1'b0);
            n++;
        end
        if (!m_stream) fail_now({tag, "_start_timeout"}, n);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((fifo_q.size() > 0 || held > 0 || inflight > 0 || pend_q.size() > 0) && n < 3000) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
        if (n >= 3000) fail_now({tag, "_drain_timeout"}, n);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},   32'(bus.fifo_rd_en_o),   32'd0);
        check({tag, "_m_valid"}, 32'(bus.m_valid_o),      32'd0);
        check({tag, "_m_data"},  32'(bus.m_data_o),       32'd0);
        check({tag, "_seq"},     32'(bus.seq_error_o),    32'd0);
        check({tag, "_und"},     32'(bus.underrun_o),     32'd0);
        check({tag, "_und_cnt"}, 32'(bus.underrun_cnt_o), 32'd0);
    endtask

    // Monitor: per-cycle comparison against the model, then advance the model across the edge
    always @(negedge rd_clk_i) begin : monitor
        logic [15:0] e;
        bit          flush, rd_exp, rdv_ok, xfer_m;
        pend_t       p;
        if (!sys_rst_n) begin
            check_all_zero("in_reset");
            fifo_q.delete();
            exp_q.delete();
            pend_q.delete();
            m_prime = 0; m_stream = 0; lower_m = 0; armed = 0;
            exp_seq = 0; exp_und = 0; held = 0; inflight = 0; exp_cnt = 0; ref_m = '0;
        end else begin
            flush  = bus.fifo_rst_busy_i;
            rd_exp = m_stream && !flush && !bus.fifo_empty_i && (held + inflight < BUF);
            check("rd_en",        32'(bus.fifo_rd_en_o),   32'(rd_exp));
            check("m_valid",      32'(bus.m_valid_o),      32'(held > 0));
            check("seq_error",    32'(bus.seq_error_o),    32'(exp_seq));
            check("underrun",     32'(bus.underrun_o),     32'(exp_und));
            check("underrun_cnt", 32'(bus.underrun_cnt_o), 32'(exp_cnt));
            if (bus.m_valid_o && bus.m_ready_i) begin
                if (exp_q.size() == 0) begin
                    fail_now("spurious_beat", int'(bus.m_data_o));
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'(bus.m_data_o), 32'(e));
                    if (!flush) begin
                        if (armed && e != 16'(ref_m + 16'd1)) exp_seq = 1;
                        ref_m = e;
                        armed = 1;
                    end
                end
            end
            if (bus.fifo_rd_en_o) begin
                if (fifo_q.size() == 0) begin
                    fail_now("read_while_empty", cyc);
                end else begin
                    p.due = cyc + RD_LAT;
                    p.d   = fifo_q.pop_front();
                    pend_q.push_back(p);
                end
            end
            rdv_ok = bus.fifo_rd_valid_i && (inflight > 0);
            if (bus.fifo_rd_valid_i && pend_q.size() > 0 && pend_q[0].due == cyc) void'(pend_q.pop_front());
            if (m_stream && bus.m_ready_i && held == 0 && inflight == 0) begin
                exp_und = 1;
                if (exp_cnt < 65535) exp_cnt++;
            end
            if (flush) begin
                m_prime = 0; m_stream = 0; held = 0; inflight = 0; lower_m = 0; armed = 0;
            end else begin
                xfer_m   = (held > 0) && bus.m_ready_i;
                inflight = inflight + int'(rd_exp) - int'(rdv_ok);
                if (xfer_m) begin
                    if (lower_m) held--;
                    lower_m = !lower_m;
                end
                if (rdv_ok) held++;
                if (m_prime && bus.fifo_prog_full_i) begin
                    m_prime  = 0;
                    m_stream = 1;
                end else if (!m_prime && !m_stream) begin
                    m_prime = 1;
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int c0;
        int n;
        bus.fifo_rst_busy_i  = 1'b1;
        bus.fifo_empty_i     = 1'b1;
        bus.fifo_prog_full_i = 1'b0;
        bus.fifo_rd_valid_i  = 1'b0;
        bus.fifo_rdata_i     = '0;
        bus.m_ready_i        = 1'b0;

        // Reset, then FIFO reset-busy for 10 cycles
        repeat (3) step(1'b0, 1'b0, 1'b1);
        sys_rst_n = 1'b1;
        repeat (10) step(1'b0, 1'b0, 1'b1);

        // Counter pattern, start on prog_full, ready high
        fill_to_stream("start", 1);
        repeat (200) step(1'($urandom_range(1)), 1'b1, 1'b0);

        // Backpressure pause, then random ready
        repeat (20) step(1'b0, 1'b0, 1'b0);
        check("pause_credits", 32'(held + inflight), 32'(BUF));
        repeat (300) step(1'($urandom_range(1)), 1'($urandom_range(3) != 0), 1'b0);
        drain("phase_a");
        check("phase_a_seq", 32'(bus.seq_error_o), 32'd0);

        // Directed starve: exactly five counted cycles
        repeat (3) step(1'b0, 1'b0, 1'b0);
        c0 = exp_cnt;
        repeat (5) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("underrun_cnt_plus5", 32'(bus.underrun_cnt_o), 32'(c0 + 5));
        check("underrun_sticky",    32'(bus.underrun_o),     32'd1);

        // Mid-stream asynchronous reset with reads outstanding
        n = 0;
        while (inflight == 0 && n < 500) begin
            step(1'b1, 1'($urandom_range(1)), 1'b0);
            n++;
        end
        if (inflight == 0) fail_now("inflight_timeout", n);
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) step(1'b0, 1'b1, 1'b0);
        sys_rst_n = 1'b1;

        // Restart needs a fresh prog_full; pattern crosses the 16-bit wrap
        gen_b   = 16'hFFF0;
        gen_idx = 0;
        fill_to_stream("restart", 3);
        repeat (200) step(1'($urandom_range(1)), 1'($urandom_range(3) != 0), 1'b0);
        drain("phase_b");
        check("wrap_seq", 32'(bus.seq_error_o), 32'd0);

        // Corrupted word: 0x0010_0011 in place of 0x0004_0005
        sys_rst_n = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0);
        sys_rst_n  = 1'b1;
        gen_b      = 16'h0000;
        gen_idx    = 0;
        corrupt_en = 1'b1;
        fill_to_stream("corrupt", 1);
        repeat (100) step(1'($urandom_range(1)), 1'b1, 1'b0);
        drain("phase_c");
        check("corrupt_seq", 32'(bus.seq_error_o), 32'd1);

        // Long starve saturates the underrun counter
        repeat (65540) step(1'b0, 1'b1, 1'b0);
        check("underrun_sat", 32'(bus.underrun_cnt_o), 32'h0000_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
